// File: rtl/credit_rx_buffer.sv
// rtl/credit_rx_buffer.sv - credit-link receiver FIFO with show-ahead output and delayed credit return
// Optional macro CREDIT_RX_OVF_CHECK_EN adds the sticky o_ovf overflow flag.
module credit_rx_buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int N_CREDITS    = 10,
  parameter int CREDIT_DELAY = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH-1:0]          i_data,
  output logic                           o_valid,
  output logic [DATA_WIDTH-1:0]          o_data,
  input  logic                           i_ready,
  output logic                           o_credit,
`ifdef CREDIT_RX_OVF_CHECK_EN
  output logic                           o_ovf,
`endif
  output logic [$clog2(N_CREDITS+1)-1:0] o_count
);

  localparam int CNT_W = $clog2(N_CREDITS + 1);
  localparam int PTR_W = (N_CREDITS > 1) ? $clog2(N_CREDITS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_CREDITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_CREDITS);

  logic [DATA_WIDTH-1:0]   mem_q [N_CREDITS];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CREDIT_DELAY-1:0] credit_pipe_q, credit_pipe_d;
  logic                    full, deq, enq;

  assign o_valid  = (count_q != '0);
  assign o_data   = mem_q[rd_ptr_q];
  assign o_count  = count_q;
  assign o_credit = credit_pipe_q[CREDIT_DELAY-1];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    full     = (count_q == FULL_CNT);
    deq      = o_valid & i_ready;
    enq      = i_valid & (~full | deq);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  generate
    if (CREDIT_DELAY == 1) begin : g_credit_one
      assign credit_pipe_d = deq;
    end else begin : g_credit_multi
      assign credit_pipe_d = {credit_pipe_q[CREDIT_DELAY-2:0], deq};
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      credit_pipe_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      credit_pipe_q <= credit_pipe_d;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= i_data;
  end

`ifdef CREDIT_RX_OVF_CHECK_EN
  logic drop;
  logic ovf_q;

  assign drop  = i_valid & full & ~deq;
  assign o_ovf = ovf_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && drop) $error("credit_rx_buffer: overflow write dropped at count %0d", count_q);
  end
`endif

endmodule

// File: tb/tb_credit_rx_buffer.sv
// tb/tb_credit_rx_buffer.sv - vector table, randomized queue model and reset corner cases for credit_rx_buffer
// Drives a CREDIT_DELAY=1 and a CREDIT_DELAY=3 instance from the same inputs.
module tb_credit_rx_buffer;

  localparam int DW = 32;
  localparam int N  = 10;
  localparam int CW = $clog2(N + 1);

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        eov;
    logic [31:0] edata;
    logic        ecr;
    int          ecnt;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [DW-1:0] i_data = '0;

  logic          a_valid, a_credit, b_valid, b_credit;
  logic [DW-1:0] a_data, b_data;
  logic [CW-1:0] a_count, b_count;
`ifdef CREDIT_RX_OVF_CHECK_EN
  logic          a_ovf, b_ovf;
`endif

  int n_pass  = 0;
  int n_total = 0;

  vec_t          vecs[$];
  logic [31:0]   q[$];
  logic          ca[$];
  logic          cb[$];

  always #5 clock = ~clock;

  credit_rx_buffer #(.DATA_WIDTH(DW), .N_CREDITS(N), .CREDIT_DELAY(1)) dut_a (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .o_valid(a_valid), .o_data(a_data), .i_ready(i_ready), .o_credit(a_credit),
`ifdef CREDIT_RX_OVF_CHECK_EN
    .o_ovf(a_ovf),
`endif
    .o_count(a_count)
  );

  credit_rx_buffer #(.DATA_WIDTH(DW), .N_CREDITS(N), .CREDIT_DELAY(3)) dut_b (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .o_valid(b_valid), .o_data(b_data), .i_ready(i_ready), .o_credit(b_credit),
`ifdef CREDIT_RX_OVF_CHECK_EN
    .o_ovf(b_ovf),
`endif
    .o_count(b_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic r,
                              input logic eov, input logic [31:0] ed, input logic ecr, input int ecnt);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.eov = eov; t.edata = ed; t.ecr = ecr; t.ecnt = ecnt;
    return t;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    @(posedge clock);
    #1;
    i_valid = v;
    i_data  = d;
    i_ready = r;
  endtask

  initial begin
    logic        v, r, hs, eov;
    logic [31:0] d;

    // Latency: token 0xA5 in cycle t, consumer ready from t+1.
    vecs.push_back(mk(1, 'hA5, 0, 0, 0,     0, 0));
    vecs.push_back(mk(0, 0,    1, 1, 'hA5,  0, 1));
    vecs.push_back(mk(0, 0,    1, 0, 0,     1, 0));
    vecs.push_back(mk(0, 0,    0, 0, 0,     0, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1, i, 0, i > 0, 0, 0, i));
    vecs.push_back(mk(1, 'hDEAD, 0, 1, 0, 0, 10));
    vecs.push_back(mk(1, 'h55,   1, 1, 0, 0, 10));
    for (int j = 0; j < 9; j++) vecs.push_back(mk(0, 0, 1, 1, j + 1, 1, 10 - j));
    vecs.push_back(mk(0, 0, 1, 1, 'h55, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 25; k++)
      vecs.push_back(mk(1, 'h100 + k, 1, k > 0, 'h100 + k - 1, k >= 2, (k > 0) ? 1 : 0));
    vecs.push_back(mk(0, 0, 1, 1, 'h118, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clock);
    #1;
    chk("rst_a_valid",  32'(a_valid),  0);
    chk("rst_a_credit", 32'(a_credit), 0);
    chk("rst_a_count",  32'(a_count),  0);
    chk("rst_b_valid",  32'(b_valid),  0);
    chk("rst_b_count",  32'(b_count),  0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].r);
      @(negedge clock);
      chk($sformatf("vec%0d_valid", i),  32'(a_valid),  32'(vecs[i].eov));
      chk($sformatf("vec%0d_credit", i), 32'(a_credit), 32'(vecs[i].ecr));
      chk($sformatf("vec%0d_count", i),  32'(a_count),  32'(vecs[i].ecnt));
      if (vecs[i].eov) chk($sformatf("vec%0d_data", i), a_data, vecs[i].edata);
    end
`ifdef CREDIT_RX_OVF_CHECK_EN
    chk("ovf_a_sticky", 32'(a_ovf), 1);
    chk("ovf_b_sticky", 32'(b_ovf), 1);
`endif

    repeat (4) drive(0, 0, 0);

    // Randomized traffic against a queue model; credits modelled as delay lines.
    ca.push_back(1'b0);
    repeat (3) cb.push_back(1'b0);
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 9) < 6);
      d = $urandom;
      r = $urandom_range(0, 1);
      drive(v, d, r);
      @(negedge clock);
      eov = (q.size() != 0);
      chk($sformatf("rnd%0d_a_valid", c),  32'(a_valid),  32'(eov));
      chk($sformatf("rnd%0d_a_count", c),  32'(a_count),  q.size());
      chk($sformatf("rnd%0d_a_credit", c), 32'(a_credit), 32'(ca[0]));
      chk($sformatf("rnd%0d_b_count", c),  32'(b_count),  q.size());
      chk($sformatf("rnd%0d_b_credit", c), 32'(b_credit), 32'(cb[0]));
      if (eov) begin
        chk($sformatf("rnd%0d_a_data", c), a_data, q[0]);
        chk($sformatf("rnd%0d_b_data", c), b_data, q[0]);
      end
      hs = eov && r;
      void'(ca.pop_front());
      ca.push_back(hs);
      void'(cb.pop_front());
      cb.push_back(hs);
      if (hs) void'(q.pop_front());
      if (v && q.size() < N) q.push_back(d);
    end

    drive(0, 0, 0);
    reset = 1'b1;
    drive(0, 0, 0);
    reset = 1'b0;

    // CREDIT_DELAY=3 pulse timing, then reset while a credit is in flight.
    drive(1, 'h11, 0);
    drive(0, 0, 1);
    @(negedge clock);
    chk("dly_b_head", b_data, 'h11);
    drive(0, 0, 0);
    @(negedge clock);
    chk("dly_b_c2", 32'(b_credit), 0);
    drive(0, 0, 0);
    @(negedge clock);
    chk("dly_b_c3", 32'(b_credit), 0);
    drive(0, 0, 0);
    @(negedge clock);
    chk("dly_b_c4_pulse", 32'(b_credit), 1);
    drive(1, 'h22, 0);
    @(negedge clock);
    chk("dly_b_c5", 32'(b_credit), 0);
    drive(1, 'h33, 1);
    @(negedge clock);
    chk("dly_b_head2", b_data, 'h22);
    drive(0, 0, 0);
    #1;
    chk("pre_rst_b_valid",  32'(b_valid),  1);
    chk("pre_rst_a_credit", 32'(a_credit), 1);
    reset = 1'b1;
    #1;
    chk("async_rst_b_valid",  32'(b_valid),  0);
    chk("async_rst_a_valid",  32'(a_valid),  0);
    chk("async_rst_a_credit", 32'(a_credit), 0);
    chk("async_rst_b_count",  32'(b_count),  0);
    drive(0, 0, 0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 0);
      @(negedge clock);
      chk($sformatf("post_rst%0d_b_credit", c), 32'(b_credit), 0);
      chk($sformatf("post_rst%0d_b_valid", c),  32'(b_valid),  0);
    end
    chk("post_rst_b_count", 32'(b_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/credit_rx_buffer.md
Name: credit_rx_buffer

Overview:
- Receiver-side stage of the latency-insensitive credit link, directly downstream of the sender's credit counter.
- Buffers tokens arriving on the link in an N_CREDITS-deep FIFO and presents them to the consuming pearl with valid/ready.
- Returns one single-cycle credit pulse per dequeued token; this pulse drives the sender counter's increment input.

Parameters:
- DATA_WIDTH, 32, token payload width in bits.
- N_CREDITS, 10, FIFO depth. Must equal the sender's credit count. Need not be a power of two. Minimum 1.
- CREDIT_DELAY, 1, register stages on the credit return path, modelling link wire latency. Minimum 1.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-high.
- i_valid  in  1  token present on the link. Sender asserts it only while holding a credit.
- i_data  in  DATA_WIDTH  token payload, sampled when i_valid is high.
- o_valid  out  1  FIFO head valid to consumer.
- o_data  out  DATA_WIDTH  FIFO head payload. Meaningful only while o_valid is high.
- i_ready  in  1  consumer accepts head; ready latency 0.
- o_credit  out  1  one-cycle credit return pulse to the sender's increment input.
- o_count  out  $clog2(N_CREDITS+1)  current occupancy.

Behaviour:
- Storage: circular buffer of N_CREDITS entries; wr_ptr, rd_ptr, count registers.
  - Pointers wrap from N_CREDITS-1 to 0 explicitly, not by natural overflow.
  - Memory contents are not reset.
- Reset (asynchronous): count, wr_ptr, rd_ptr, credit pipe and overflow flag clear immediately. Results: o_valid=0, o_credit=0, o_count=0. o_data is don't-care.
- Enqueue: i_valid high at an edge writes i_data to mem[wr_ptr] and advances wr_ptr.
  - No bypass. A token written into an empty FIFO at edge k makes o_valid high from edge k onward (first visible in the next cycle).
- Show-ahead output:
  - o_valid = (count != 0).
  - o_data = mem[rd_ptr], combinational from registered state; no extra read latency.
- Dequeue: handshake = o_valid & i_ready. On a handshake, rd_ptr advances and the head leaves.
- Count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue; both pointers still advance.
  - o_count = count.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle at count=N_CREDITS: accepted. The freed slot is reused; count stays N_CREDITS.
  - Enqueue at count=0: stored; o_valid rises next cycle.
- Overflow: i_valid at count=N_CREDITS with no dequeue is a protocol violation.
  - The write is dropped; pointers and count are unchanged.
  - Stored data is never corrupted.
- Underflow: impossible by construction, since dequeue requires o_valid.
- Credit return: a CREDIT_DELAY-stage shift register carries the handshake bit.
  - A handshake in cycle c produces o_credit high for exactly cycle c+CREDIT_DELAY.
  - One pulse per dequeue. Back-to-back dequeues give back-to-back pulses, never merged or dropped.
  - o_credit is a register output.
- Reset mid-operation: buffered tokens and in-flight credits are discarded. This is consistent because the sender counter resets to N_CREDITS on the same reset.
- Credit invariant: count + credits in pipe + sender credits = N_CREDITS. The bench checks this every cycle when paired with the sender.

Optional Feature:
- Macro: CREDIT_RX_OVF_CHECK_EN.
- Defined:
  - Adds output port o_ovf (1 bit), a sticky flag set on the edge after any dropped overflow write.
  - Cleared only by reset.
  - Simulation also emits $error with the current count.
- Undefined:
  - No o_ovf port and no check logic.
  - Overflow writes are still silently dropped as specified above.

Test Plan:
- Reset and latency, CREDIT_DELAY=1:
  - Stimulus: assert reset; then i_valid=1, i_data=0xA5 in cycle t; i_ready=1 from cycle t+1.
  - Response: all outputs 0 during reset. o_valid=1 and o_data=0xA5 in t+1. o_credit=1 only in t+2. o_count returns to 0 in t+2.
- Fill and drain, N_CREDITS=10:
  - Stimulus: 10 consecutive writes 0..9 with i_ready=0; then i_ready=1 for 10 cycles.
  - Response: o_count reaches 10. Data emerges 0..9 in order. Exactly 10 consecutive o_credit pulses. o_valid ends 0.
- Wrap and steady state:
  - Stimulus: stream 25 tokens (0x100..0x118) with i_ready=1 continuously.
  - Response: in-order output; o_count holds 1 after the first token; pointers wrap twice without data loss.
- Overflow:
  - Stimulus: FIFO full, i_valid=1 with data 0xDEAD, i_ready=0.
  - Response: o_count stays 10. Drained data excludes 0xDEAD. With CREDIT_RX_OVF_CHECK_EN, o_ovf=1 next cycle and stays 1 until reset.
- Full with simultaneous enqueue and dequeue:
  - Stimulus: count=10, i_valid=1 and i_ready=1 in the same cycle.
  - Response: count stays 10, token accepted, one credit pulse, no overflow flag.
- Delay and reset mid-flight, CREDIT_DELAY=3:
  - Stimulus: one handshake in cycle c gives a pulse in c+3. A second handshake in cycle d, then reset asserted asynchronously in d+1.
  - Response: o_valid and o_credit drop immediately on reset. No pulse appears after release. o_count=0.
